// File: rtl/kgprisc_boot_loader.sv
// rtl/kgprisc_boot_loader.sv - streams a program into instruction memory, then runs the core to halt or timeout
module kgprisc_boot_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int RST_HOLD   = 4,
  parameter int MAX_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH:0]   load_count,
  input  logic                  in_valid,
  input  logic [31:0]           in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  input  logic [31:0]           halt_reg,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [31:0]           cycle_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [ADDR_WIDTH:0] DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE       = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [31:0]         HOLD_LAST = 32'(RST_HOLD - 1);
  localparam logic [31:0]         CYC_LAST  = 32'(MAX_CYCLES - 1);

  logic [2:0]          state;
  logic [ADDR_WIDTH:0] count;
  logic [ADDR_WIDTH:0] ptr;
  logic [31:0]         hold_cnt;
  logic                count_ok;
  logic                handshake;
  logic                last_word;
  logic                halt_hit;
  logic                budget_hit;

  assign count_ok   = (load_count != '0) && (load_count <= DEPTH);
  assign in_ready   = (state == S_LOAD);
  assign handshake  = in_ready & in_valid;
  assign imem_we    = handshake;
  assign imem_addr  = in_ready ? ptr[ADDR_WIDTH-1:0] : '0;
  assign imem_wdata = handshake ? in_data : '0;
  // ptr carries one extra bit so a full-depth load still compares exactly against count-1
  assign last_word  = (ptr == count - ONE);
  assign halt_hit   = (halt_reg == 32'd1);
  assign budget_hit = (cycle_count == CYC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      count       <= '0;
      ptr         <= '0;
      hold_cnt    <= '0;
      cpu_rst     <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (load_start) begin
            if (count_ok) begin
              state       <= S_LOAD;
              count       <= load_count;
              ptr         <= '0;
              done        <= 1'b0;
              error       <= 1'b0;
              cycle_count <= '0;
              cpu_rst     <= 1'b1;
              busy        <= 1'b1;
            end else begin
              error <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (handshake) begin
            ptr <= ptr + ONE;
            if (last_word) begin
              state    <= S_HOLD;
              hold_cnt <= '0;
            end
          end
        end
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state   <= S_RUN;
            cpu_rst <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 32'd1;
          end
        end
        S_RUN: begin
          cycle_count <= cycle_count + 32'd1;
          // halt takes priority when it coincides with the last budgeted cycle
          if (halt_hit) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (budget_hit) begin
            state <= S_DONE;
            done  <= 1'b1;
            error <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kgprisc_boot_loader.sv
// tb/tb_kgprisc_boot_loader.sv - randomized self-checking bench for kgprisc_boot_loader
module tb_kgprisc_boot_loader;

  localparam int AW   = 10;
  localparam int HOLD = 4;
  localparam int MAXC = 50;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_start = 1'b0;
  logic [AW:0]   load_count = '0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_data = '0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [31:0]   halt_reg = '0;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          error;
  logic [31:0]   cycle_count;

  kgprisc_boot_loader #(.ADDR_WIDTH(AW), .RST_HOLD(HOLD), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_count(load_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .halt_reg(halt_reg), .cpu_rst(cpu_rst), .busy(busy), .done(done),
    .error(error), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
    int            c;
  } wr_t;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;
  int          stray_we = 0;
  wr_t         wq[$];
  logic [31:0] words [0:1023];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    wr_t e;
    if (imem_we === 1'b1) begin
      e.a = imem_addr;
      e.d = imem_wdata;
      e.c = cyc;
      wq.push_back(e);
      if (in_valid !== 1'b1) stray_we++;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; load_start = 1'b0; in_valid = 1'b0; halt_reg = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic start_load(input int n);
    @(posedge clk); #1;
    load_start = 1'b1; load_count = 11'(n);
    @(posedge clk); #1;
    load_start = 1'b0; load_count = 11'($urandom);
  endtask

  // Offers words[0..n-1]; in_valid follows pat (LSB first) or a random gap percentage.
  task automatic drive_load(input int n, input bit use_pat, input logic [15:0] pat,
                            input int gappct, output bit ok);
    int i;
    int t;
    i = 0; t = 0;
    while (i < n && t < 5000) begin
      in_valid = use_pat ? pat[t % 16] : (int'($urandom_range(99)) >= gappct);
      in_data  = in_valid ? words[i] : $urandom;
      @(negedge clk);
      if (in_valid && in_ready) i++;
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    ok = (i == n);
  endtask

  task automatic wait_run(output bit ok, output int fall_c);
    ok = 1'b0; fall_c = -1;
    for (int j = 0; j < 3000; j++) begin
      @(negedge clk);
      if (cpu_rst === 1'b0) begin
        ok = 1'b1; fall_c = cyc;
        break;
      end
    end
  endtask

  // Called at the negedge of the first RUN cycle; k = RUN edge on which halt_reg reads 1 (0 = never).
  task automatic run_halt(input int k, output bit ok);
    if (k > 0) begin
      if (k > 1) begin
        repeat (k - 1) @(posedge clk);
        #1;
      end
      halt_reg = 32'd1;
      @(posedge clk); #1;
      halt_reg = 32'd0;
    end
    ok = 1'b0;
    for (int j = 0; j < 300; j++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  function automatic int log_errors(input int n);
    int bad;
    bad = 0;
    if (wq.size() != n) return n + 1;
    for (int i = 0; i < n; i++)
      if (wq[i].a !== AW'(i % 1024) || wq[i].d !== words[i]) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; load_start = 1'b1; load_count = 11'd4;
    @(negedge clk);
    tests_run++;
    if ({cpu_rst, in_ready, imem_we, busy, done, error} !== 6'b100000) begin
      tests_failed++;
      $display("FAIL reset_flags got %b want 100000", {cpu_rst, in_ready, imem_we, busy, done, error});
    end
    tests_run++;
    if (imem_addr !== '0 || imem_wdata !== '0 || cycle_count !== '0) begin
      tests_failed++;
      $display("FAIL reset_values addr %0h wdata %0h cycles %0d want 0", imem_addr, imem_wdata, cycle_count);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; load_start = 1'b0;
  endtask

  task automatic test_nominal();
    bit ok, ok2, ok3;
    int fall_c, bad;
    do_reset(); wq.delete(); stray_we = 0;
    for (int i = 0; i < 4; i++) words[i] = 32'hA0000001 + 32'(i);
    @(posedge clk); #1;
    load_start = 1'b1; load_count = 11'd4;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL nom_ready_early got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    load_start = 1'b0;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      tests_failed++; $display("FAIL nom_ready_rise ready %b busy %b want 1 1", in_ready, busy);
    end
    @(posedge clk); #1;
    drive_load(4, 1'b0, 16'h0, 0, ok);
    wait_run(ok2, fall_c);
    bad = log_errors(4);
    tests_run++;
    if (!ok || bad != 0) begin
      tests_failed++; $display("FAIL nom_writes loaded %b bad %0d size %0d want 0 bad of 4", ok, bad, wq.size());
    end
    tests_run++;
    if (wq.size() != 4 || wq[3].c - wq[0].c != 3) begin
      tests_failed++; $display("FAIL nom_consecutive span %0d want 3", wq.size() == 4 ? wq[3].c - wq[0].c : -1);
    end
    tests_run++;
    if (!ok2 || wq.size() != 4 || fall_c != wq[3].c + HOLD + 1) begin
      tests_failed++; $display("FAIL nom_cpu_rst_fall got cycle %0d want %0d", fall_c, wq.size() == 4 ? wq[3].c + HOLD + 1 : -1);
    end
    run_halt(20, ok3);
    tests_run++;
    if (!ok3 || done !== 1'b1 || error !== 1'b0 || cycle_count !== 32'd20) begin
      tests_failed++; $display("FAIL nom_halt done %b error %b cycles %0d want 1 0 20", done, error, cycle_count);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad;
    do_reset(); wq.delete(); stray_we = 0;
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    start_load(3);
    drive_load(3, 1'b1, 16'b101001, 0, ok);
    repeat (3) @(negedge clk);
    bad = log_errors(3);
    tests_run++;
    if (!ok || bad != 0) begin
      tests_failed++; $display("FAIL bp_writes bad %0d size %0d want 0 bad of 3", bad, wq.size());
    end
    tests_run++;
    if (stray_we != 0 || wq.size() != 3 || wq[1].c - wq[0].c != 3 || wq[2].c - wq[1].c != 2) begin
      tests_failed++; $display("FAIL bp_gaps stray %0d size %0d want 0 stray, gaps 3,2", stray_we, wq.size());
    end
  endtask

  task automatic test_bad_counts();
    int counts[2] = '{0, 1025};
    foreach (counts[k]) begin
      do_reset(); wq.delete();
      start_load(counts[k]);
      @(negedge clk);
      tests_run++;
      if ({error, in_ready, cpu_rst, busy} !== 4'b1010) begin
        tests_failed++;
        $display("FAIL bad_count_%0d err/ready/cpu_rst/busy %b want 1010", counts[k], {error, in_ready, cpu_rst, busy});
      end
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      tests_run++;
      if (in_ready !== 1'b0 || busy !== 1'b0 || wq.size() != 0) begin
        tests_failed++;
        $display("FAIL bad_count_idle_%0d ready %b busy %b writes %0d want 0 0 0", counts[k], in_ready, busy, wq.size());
      end
    end
  endtask

  task automatic test_full_depth();
    bit ok;
    int bad;
    do_reset(); wq.delete(); stray_we = 0;
    for (int i = 0; i < 1024; i++) words[i] = $urandom;
    start_load(1024);
    drive_load(1024, 1'b0, 16'h0, 0, ok);
    in_valid = 1'b1; in_data = 32'hDEADBEEF;
    repeat (10) @(negedge clk);
    in_valid = 1'b0;
    bad = log_errors(1024);
    tests_run++;
    if (!ok || bad != 0) begin
      tests_failed++; $display("FAIL full_writes bad %0d size %0d want 0 bad of 1024", bad, wq.size());
    end
    tests_run++;
    if (wq.size() == 0 || wq[wq.size()-1].a !== 10'd1023 || in_ready !== 1'b0 || busy !== 1'b1) begin
      tests_failed++; $display("FAIL full_wrap last addr %0d ready %b busy %b want 1023 0 1",
                              wq.size() == 0 ? -1 : int'(wq[wq.size()-1].a), in_ready, busy);
    end
  endtask

  task automatic test_timeout();
    bit ok, ok2;
    int fall_c;
    int ks[2] = '{0, MAXC};
    foreach (ks[k]) begin
      do_reset(); wq.delete();
      words[0] = $urandom; words[1] = $urandom;
      start_load(2);
      drive_load(2, 1'b0, 16'h0, 20, ok);
      wait_run(ok, fall_c);
      run_halt(ks[k], ok2);
      tests_run++;
      if (!ok2 || done !== 1'b1 || error !== (ks[k] == 0) || cycle_count !== 32'(MAXC)) begin
        tests_failed++;
        $display("FAIL timeout_k%0d done %b error %b cycles %0d want 1 %0d %0d", ks[k], done, error, cycle_count, ks[k] == 0, MAXC);
      end
      halt_reg = 32'd1;
      repeat (5) @(negedge clk);
      halt_reg = 32'd0;
      tests_run++;
      if (cycle_count !== 32'(MAXC) || done !== 1'b1 || cpu_rst !== 1'b0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL timeout_frozen_k%0d cycles %0d done %b cpu_rst %b busy %b want %0d 1 0 0", ks[k], cycle_count, done, cpu_rst, busy, MAXC);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok, ok2;
    int fall_c, bad;
    do_reset(); wq.delete();
    start_load(4);
    in_valid = 1'b1; in_data = 32'h11111111;
    @(posedge clk); #1;
    in_data = 32'h22222222;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({in_ready, imem_we, cpu_rst, busy} !== 4'b0010 || wq.size() != 2) begin
      tests_failed++;
      $display("FAIL rst_in_load ready/we/cpu_rst/busy %b writes %0d want 0010 2", {in_ready, imem_we, cpu_rst, busy}, wq.size());
    end
    in_valid = 1'b0;
    do_reset(); wq.delete();
    words[0] = $urandom; words[1] = $urandom;
    start_load(2);
    drive_load(2, 1'b0, 16'h0, 0, ok);
    wait_run(ok, fall_c);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (cycle_count !== '0 || cpu_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_in_run cycles %0d cpu_rst %b busy %b done %b want 0 1 0 0", cycle_count, cpu_rst, busy, done);
    end
    wq.delete();
    for (int i = 0; i < 4; i++) words[i] = $urandom;
    start_load(4);
    drive_load(4, 1'b0, 16'h0, 25, ok);
    wait_run(ok2, fall_c);
    run_halt(7, ok2);
    bad = log_errors(4);
    tests_run++;
    if (!ok || !ok2 || bad != 0 || cycle_count !== 32'd7 || error !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_fresh_load bad %0d cycles %0d error %b want 0 7 0", bad, cycle_count, error);
    end
  endtask

  // Successive programs launched straight from DONE, no reset in between.
  task automatic test_back_to_back();
    bit ok, ok2;
    int n, k, fall_c, bad, exp_cnt;
    bit exp_err;
    for (int it = 0; it < 6; it++) begin
      wq.delete(); stray_we = 0;
      n = $urandom_range(1, 20);
      k = $urandom_range(1, 70);
      exp_cnt = (k > MAXC) ? MAXC : k;
      exp_err = (k > MAXC);
      for (int i = 0; i < n; i++) words[i] = $urandom;
      start_load(n);
      @(negedge clk);
      tests_run++;
      if ({done, error, cpu_rst, in_ready} !== 4'b0011 || cycle_count !== '0) begin
        tests_failed++;
        $display("FAIL b2b_restart_%0d done/err/cpu_rst/ready %b cycles %0d want 0011 0", it, {done, error, cpu_rst, in_ready}, cycle_count);
      end
      @(posedge clk); #1;
      drive_load(n, 1'b0, 16'h0, 30, ok);
      wait_run(ok2, fall_c);
      bad = log_errors(n);
      tests_run++;
      if (!ok || !ok2 || bad != 0 || stray_we != 0 || fall_c != wq[wq.size()-1].c + HOLD + 1) begin
        tests_failed++;
        $display("FAIL b2b_load_%0d n %0d bad %0d stray %0d fall %0d want 0 0 %0d", it, n, bad, stray_we, fall_c,
                 wq.size() == 0 ? -1 : wq[wq.size()-1].c + HOLD + 1);
      end
      run_halt(k, ok);
      tests_run++;
      if (!ok || done !== 1'b1 || error !== exp_err || cycle_count !== 32'(exp_cnt)) begin
        tests_failed++;
        $display("FAIL b2b_run_%0d k %0d done %b error %b cycles %0d want 1 %0d %0d", it, k, done, error, cycle_count, exp_err, exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_bad_counts();
    test_full_depth();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
